// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard and stall controller for a 5-stage in-order pipeline.
//
// Resolves three event classes in priority order:
//   1. data-memory wait  (freeze IF/ID/EX/MEM until dmem_ready or timeout)
//   2. taken branch/jump resolved in MEM (flush IF_ID and ID_EX)
//   3. load-use hazard   (one-cycle bubble inserted into EX)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rs1D, rs2D               source registers of the instruction in ID
//   rdE, mem_readE           destination / is-load of the instruction in EX
//   mem_readM, mem_writeM    MEM instruction is a load / store
//   branch_takenM            redirect resolved in MEM
//   dmem_ready               data memory completes the MEM access this cycle
//   stallF, stallD, stallE   hold PC, IF_ID, ID_EX
//   hold_M                   hold EX_MEM (freeze MEM stage)
//   flushD, flushE           clear IF_ID / ID_EX to NOP on next edge
//   mem_err                  registered one-cycle pulse on memory wait timeout
//   stall_cnt                saturating count of cycles with stallF=1
//   state_o                  current FSM state (IDLE=0, MEM_WAIT=1, LU_STALL=2)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [7:0] WAIT_MAX = 8'd255,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdE,
    input  logic             mem_readE,
    input  logic             mem_readM,
    input  logic             mem_writeM,
    input  logic             branch_takenM,
    input  logic             dmem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             hold_M,
    output logic             flushD,
    output logic             flushE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        LU_STALL = 2'd2,
        UNUSED   = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_next;
    logic       err_next;

    logic memop, loaduse;
    logic hold;      // memory hold active this cycle
    logic evaluate;  // no hold: branch / load-use rules may act
    logic allow_lu;  // load-use may raise a stall in this state
    logic stallF_raw, stallD_raw, stallE_raw, hold_M_raw, flushD_raw, flushE_raw;

    assign memop   = mem_readM | mem_writeM;
    assign loaduse = mem_readE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = IDLE;
        wait_next  = wait_cnt;
        err_next   = 1'b0;
        hold       = 1'b0;
        evaluate   = 1'b0;
        allow_lu   = 1'b0;
        stallF_raw = 1'b0;
        stallD_raw = 1'b0;
        stallE_raw = 1'b0;
        hold_M_raw = 1'b0;
        flushD_raw = 1'b0;
        flushE_raw = 1'b0;

        case (state)
            IDLE, LU_STALL: begin
                if (memop && !dmem_ready) begin
                    hold       = 1'b1;
                    state_next = MEM_WAIT;
                    wait_next  = 8'd1;  // this cycle is the first wait cycle
                end else begin
                    evaluate = 1'b1;
                    // The instruction in EX is a bubble during LU_STALL.
                    allow_lu = (state == IDLE);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    wait_next = 8'd0;
                    evaluate  = 1'b1;
                    allow_lu  = 1'b1;
                end else if (wait_cnt >= WAIT_MAX) begin
                    wait_next = 8'd0;
                    err_next  = 1'b1;
                    evaluate  = 1'b1;
                    allow_lu  = 1'b1;
                end else begin
                    hold       = 1'b1;
                    state_next = MEM_WAIT;
                    wait_next  = wait_cnt + 8'd1;
                end
            end
            default: begin
                // Illegal encoding: drop to IDLE with all outputs low.
                wait_next = 8'd0;
            end
        endcase

        // ID and EX were frozen during a wait, so a pending hazard between
        // them is still live on the release cycle and is handled then.
        if (hold) begin
            stallF_raw = 1'b1;
            stallD_raw = 1'b1;
            stallE_raw = 1'b1;
            hold_M_raw = 1'b1;
        end else if (evaluate) begin
            if (branch_takenM) begin
                flushD_raw = 1'b1;
                flushE_raw = 1'b1;
            end else if (allow_lu && loaduse) begin
                stallF_raw = 1'b1;
                stallD_raw = 1'b1;
                flushE_raw = 1'b1;
                state_next = LU_STALL;
            end
        end
    end

    // Control outputs are forced low while reset is asserted.
    assign stallF  = stallF_raw & ~rst;
    assign stallD  = stallD_raw & ~rst;
    assign stallE  = stallE_raw & ~rst;
    assign hold_M  = hold_M_raw & ~rst;
    assign flushD  = flushD_raw & ~rst;
    assign flushE  = flushE_raw & ~rst;
    assign state_o = state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            mem_err  <= err_next;
            if (stallF && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// Each cycle the stimulus task pushes the expected output vector into a
// scoreboard queue; the vector is popped and compared mid-cycle (negedge).
// DUT built with WAIT_MAX=4 and CNT_W=4 so timeout and saturation are short.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rdE;
    logic       mem_readE, mem_readM, mem_writeM, branch_takenM, dmem_ready;
    logic       stallF, stallD, stallE, hold_M, flushD, flushE, mem_err;
    logic [3:0] stall_cnt;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    // ctl = {stallF, stallD, stallE, hold_M, flushD, flushE}
    typedef struct packed {
        logic [5:0] ctl;
        logic [1:0] st;
        logic       err;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_HOLD  = 6'b111100;
    localparam logic [5:0] C_FLUSH = 6'b000011;
    localparam logic [5:0] C_LU    = 6'b110001;

    pipe_ctrl #(.WAIT_MAX(8'd4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
        .mem_readE(mem_readE), .mem_readM(mem_readM), .mem_writeM(mem_writeM),
        .branch_takenM(branch_takenM), .dmem_ready(dmem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .hold_M(hold_M),
        .flushD(flushD), .flushE(flushE), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(logic [5:0] ctl, logic [1:0] st, logic err, logic [3:0] cnt);
        exp_t e;
        e.ctl = ctl; e.st = st; e.err = err; e.cnt = cnt;
        return e;
    endfunction

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic mre, input logic mrm, input logic mwm,
                         input logic br, input logic rdy);
        rs1D = r1; rs2D = r2; rdE = rd;
        mem_readE = mre; mem_readM = mrm; mem_writeM = mwm;
        branch_takenM = br; dmem_ready = rdy;
    endtask

    task automatic idle_in();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Push expectation for the current cycle, compare at negedge, advance.
    task automatic cyc(input string name, input exp_t e);
        exp_t want;
        exp_t got;
        sb.push_back(e);
        @(negedge clk);
        got = mk({stallF, stallD, stallE, hold_M, flushD, flushE}, state_o, mem_err, stall_cnt);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got ctl=%b st=%0d err=%b cnt=%0d, expected ctl=%b st=%0d err=%b cnt=%0d",
                         name, got.ctl, got.st, got.err, got.cnt,
                         want.ctl, want.st, want.err, want.cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        // Hazard inputs present: outputs must still be low while in reset.
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        cyc("reset_outputs_low", mk(C_NONE, 2'd0, 1'b0, 4'd0));
        rst = 1'b0;
        idle_in();
        cyc("reset_idle", mk(C_NONE, 2'd0, 1'b0, 4'd0));
    endtask

    task automatic test_load_use();
        do_reset();
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_rs1_stall", mk(C_LU, 2'd0, 1'b0, 4'd0));
        // Inputs unchanged: LU_STALL must not re-raise the stall.
        cyc("lu_stall_state", mk(C_NONE, 2'd2, 1'b0, 4'd1));
        idle_in();
        cyc("lu_back_idle", mk(C_NONE, 2'd0, 1'b0, 4'd1));
        drive(5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_rs2_stall", mk(C_LU, 2'd0, 1'b0, 4'd1));
        idle_in();
        cyc("lu_rs2_state", mk(C_NONE, 2'd2, 1'b0, 4'd2));
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_x0_no_stall", mk(C_NONE, 2'd0, 1'b0, 4'd2));
        drive(5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_not_load", mk(C_NONE, 2'd0, 1'b0, 4'd2));
        drive(5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_no_match", mk(C_NONE, 2'd0, 1'b0, 4'd2));
    endtask

    task automatic test_mem_wait();
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("mw_hold1", mk(C_HOLD, 2'd0, 1'b0, 4'd0));
        cyc("mw_hold2", mk(C_HOLD, 2'd1, 1'b0, 4'd1));
        cyc("mw_hold3", mk(C_HOLD, 2'd1, 1'b0, 4'd2));
        dmem_ready = 1'b1;
        cyc("mw_release", mk(C_NONE, 2'd1, 1'b0, 4'd3));
        idle_in();
        cyc("mw_idle", mk(C_NONE, 2'd0, 1'b0, 4'd3));
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("mw_store_zero_wait", mk(C_NONE, 2'd0, 1'b0, 4'd3));
    endtask

    task automatic test_timeout();
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("to_hold1", mk(C_HOLD, 2'd0, 1'b0, 4'd0));
        cyc("to_hold2", mk(C_HOLD, 2'd1, 1'b0, 4'd1));
        cyc("to_hold3", mk(C_HOLD, 2'd1, 1'b0, 4'd2));
        cyc("to_hold4", mk(C_HOLD, 2'd1, 1'b0, 4'd3));
        cyc("to_release", mk(C_NONE, 2'd1, 1'b0, 4'd4));
        idle_in();
        cyc("to_err_pulse", mk(C_NONE, 2'd0, 1'b1, 4'd4));
        cyc("to_err_clear", mk(C_NONE, 2'd0, 1'b0, 4'd4));
    endtask

    task automatic test_branch();
        do_reset();
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("br_over_loaduse", mk(C_FLUSH, 2'd0, 1'b0, 4'd0));
        idle_in();
        cyc("br_one_cycle", mk(C_NONE, 2'd0, 1'b0, 4'd0));
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("br_in_hold_enter", mk(C_HOLD, 2'd0, 1'b0, 4'd0));
        cyc("br_in_hold_wait", mk(C_HOLD, 2'd1, 1'b0, 4'd1));
        dmem_ready = 1'b1;
        cyc("br_on_release", mk(C_FLUSH, 2'd1, 1'b0, 4'd2));
        idle_in();
        cyc("br_after_release", mk(C_NONE, 2'd0, 1'b0, 4'd2));
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("br_lu_first", mk(C_LU, 2'd0, 1'b0, 4'd2));
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("br_in_lu_stall", mk(C_FLUSH, 2'd2, 1'b0, 4'd3));
    endtask

    task automatic test_back_to_back();
        // Load-use straight into a memory wait from LU_STALL.
        do_reset();
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("b2b_lu", mk(C_LU, 2'd0, 1'b0, 4'd0));
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("b2b_lu_to_wait", mk(C_HOLD, 2'd2, 1'b0, 4'd1));
        dmem_ready = 1'b1;
        branch_takenM = 1'b0;
        cyc("b2b_release", mk(C_NONE, 2'd1, 1'b0, 4'd2));
        idle_in();
        cyc("b2b_idle", mk(C_NONE, 2'd0, 1'b0, 4'd2));
    endtask

    task automatic test_rst_mid_wait();
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("rw_enter", mk(C_HOLD, 2'd0, 1'b0, 4'd0));
        cyc("rw_wait1", mk(C_HOLD, 2'd1, 1'b0, 4'd1));
        rst = 1'b1;
        cyc("rw_wait2_rst", mk(C_NONE, 2'd1, 1'b0, 4'd2));
        rst = 1'b0;
        idle_in();
        cyc("rw_after_rst", mk(C_NONE, 2'd0, 1'b0, 4'd0));
        cyc("rw_no_err", mk(C_NONE, 2'd0, 1'b0, 4'd0));
    endtask

    task automatic test_saturation();
        logic [3:0] c;
        do_reset();
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            c = (i >= 15) ? 4'd15 : 4'(i);
            cyc("sat_lu", mk(C_LU, 2'd0, 1'b0, c));
            c = (i >= 14) ? 4'd15 : 4'(i + 1);
            cyc("sat_lu_stall", mk(C_NONE, 2'd2, 1'b0, c));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch();
        test_back_to_back();
        test_rst_mid_wait();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
